// File: rtl/fifo8x9_ctrl.sv
// fifo8x9_ctrl: sequencing controller for the 8x9 FIFO storage block.
// Converts push/pop requests into storage strobes, tracks occupancy and
// shadow pointers, reports status and qualifies read data.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | one cycle after reset; storage pointers cleared, no accepts
// ST_RUN   | normal operation; push/pop accepted per occupancy
// ST_FLUSH | contents discarded; pointers, count and errors cleared
`timescale 1ns/1ps

module fifo8x9_ctrl #(
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    output logic       wren,
    output logic       WrInc,
    output logic       rden,
    output logic       RdInc,
    output logic       WrPtrClr,
    output logic       RdPtrClr,
    output logic       push_ack,
    output logic       pop_ack,
    output logic       pop_valid,
    output logic [3:0] count,
    output logic       empty,
    output logic       full,
    output logic       almost_full,
    output logic [2:0] wr_ptr,
    output logic [2:0] rd_ptr,
    output logic       ovf_err,
    output logic       udf_err
);

    localparam logic [3:0] FULL_CNT = 4'(DEPTH);
    localparam logic [3:0] AF_CNT   = 4'(AF_LEVEL);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic       push_acc;
    logic       pop_acc;
    logic       ptr_clr;
    logic       clear_all;
    logic       ovf_set;
    logic       udf_set;

    logic [3:0] count_q;
    logic [2:0] wr_ptr_q;
    logic [2:0] rd_ptr_q;
    logic       ovf_q;
    logic       udf_q;
    logic       pop_valid_q;

    logic       is_empty;
    logic       is_full;

    // Status is decoded from the registered count only, so accepts never
    // loop back through outputs.
    assign is_empty = (count_q == 4'd0);
    assign is_full  = (count_q == FULL_CNT);

    // Next-state and accept decode; reset masks every strobe.
    always_comb begin
        state_d   = state_q;
        push_acc  = 1'b0;
        pop_acc   = 1'b0;
        ptr_clr   = 1'b0;
        clear_all = 1'b0;
        ovf_set   = 1'b0;
        udf_set   = 1'b0;
        case (state_q)
            ST_INIT: begin
                ptr_clr   = 1'b1;
                clear_all = 1'b1;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (flush) begin
                    // Flush wins: requests in this cycle are dropped silently.
                    state_d = ST_FLUSH;
                end else begin
                    pop_acc  = pop && !is_empty;
                    // A pop in the same cycle frees the slot the push needs.
                    push_acc = push && (!is_full || pop_acc);
                    ovf_set  = push && !push_acc;
                    udf_set  = pop && !pop_acc;
                end
            end
            ST_FLUSH: begin
                ptr_clr   = 1'b1;
                clear_all = 1'b1;
                state_d   = flush ? ST_FLUSH : ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        if (rst) begin
            push_acc = 1'b0;
            pop_acc  = 1'b0;
            ptr_clr  = 1'b0;
            ovf_set  = 1'b0;
            udf_set  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy, shadow pointers and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            count_q  <= 4'd0;
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            count_q  <= count_q + {3'd0, push_acc} - {3'd0, pop_acc};
            wr_ptr_q <= wr_ptr_q + {2'd0, push_acc};
            rd_ptr_q <= rd_ptr_q + {2'd0, pop_acc};
            ovf_q    <= ovf_q | ovf_set;
            udf_q    <= udf_q | udf_set;
        end
    end

    // Read-data qualifier: storage output is valid the cycle after a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_valid_q <= 1'b0;
        end else begin
            pop_valid_q <= pop_acc;
        end
    end

    assign wren        = push_acc;
    assign WrInc       = push_acc;
    assign push_ack    = push_acc;
    assign rden        = pop_acc;
    assign RdInc       = pop_acc;
    assign pop_ack     = pop_acc;
    assign WrPtrClr    = ptr_clr;
    assign RdPtrClr    = ptr_clr;
    assign pop_valid   = pop_valid_q;
    assign count       = count_q;
    assign empty       = is_empty;
    assign full        = is_full;
    assign almost_full = (count_q >= AF_CNT);
    assign wr_ptr      = wr_ptr_q;
    assign rd_ptr      = rd_ptr_q;
    assign ovf_err     = ovf_q;
    assign udf_err     = udf_q;

endmodule

// File: doc/fifo8x9_ctrl.md
# fifo8x9_ctrl

Sequencing controller for the 8-deep by 9-bit FIFO storage block. It turns a producer push request and a consumer pop request into the storage block's control strobes: `wren`, `WrInc`, `rden`, `RdInc`, `WrPtrClr` and `RdPtrClr`. It also tracks occupancy, reports full, empty and almost-full status, and qualifies read data. It sits between the requesters and the storage array; the storage array holds no flow-control logic of its own.

## Interface
Parameters:
- `DEPTH`, default 8: storage entries; the design is fixed to 8, and the parameter is for checking only.
- `AF_LEVEL`, default 6: `almost_full` asserts when count ≥ `AF_LEVEL`.

Ports:
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `push` input 1: producer write request for this cycle.
- `pop` input 1: consumer read request for this cycle.
- `flush` input 1: discard contents and clear both pointers.
- `wren` output 1: write strobe to storage; equals push accepted.
- `WrInc` output 1: write-pointer advance; equals push accepted.
- `rden` output 1: read strobe to storage; equals pop accepted.
- `RdInc` output 1: read-pointer advance; equals pop accepted.
- `WrPtrClr` output 1: clears the storage write pointer.
- `RdPtrClr` output 1: clears the storage read pointer.
- `push_ack` output 1: push accepted this cycle.
- `pop_ack` output 1: pop accepted this cycle.
- `pop_valid` output 1: storage `DataOut` is valid; registered, 1 cycle after `pop_ack`.
- `count` output 4: occupancy, 0..8.
- `empty` output 1: `count == 0`.
- `full` output 1: `count == 8`.
- `almost_full` output 1: `count ≥ AF_LEVEL`.
- `wr_ptr` output 3: shadow write pointer.
- `rd_ptr` output 3: shadow read pointer.
- `ovf_err` output 1: sticky flag; a push was refused while full.
- `udf_err` output 1: sticky flag; a pop was refused while empty.

## Operation
States: `INIT`, `RUN`, `FLUSH`. The state register and all counters are registered.

- `rst` high: state goes to `INIT` at the clock edge.
  - While `rst` is high, all strobe and ack outputs are forced to 0.
  - `count`=0, `wr_ptr`=`rd_ptr`=0, `pop_valid`=0, both error flags 0.
  - Status after reset: `empty`=1, `full`=0, `almost_full`=0.
- `INIT` (exactly 1 cycle):
  - `WrPtrClr`=`RdPtrClr`=1.
  - No push or pop is accepted; requests in this cycle are ignored and do not set error flags.
  - Next state is `RUN`.
- `RUN`, flush low:
  - Pop is accepted when `pop && !empty`.
  - Push is accepted when `push && (!full || pop_accepted)`. A simultaneous push and pop while full is allowed and `count` stays 8.
  - A simultaneous push and pop while empty accepts the push only; `udf_err` is set.
  - A refused push while full sets `ovf_err`. A refused pop while empty sets `udf_err`.
- `RUN`, flush high: flush has priority over push and pop in that cycle; none are accepted and no errors are set. Next state is `FLUSH`.
- `FLUSH` (exactly 1 cycle):
  - `WrPtrClr`=`RdPtrClr`=1.
  - `count`, `wr_ptr` and `rd_ptr` load 0; `ovf_err` and `udf_err` clear.
  - No accepts.
  - Next state is `RUN`; if `flush` is still high, state stays in `FLUSH`.
- Counter and pointer update rules:
  - `count` next value = `count` + push_acc − pop_acc.
  - `wr_ptr` += push_acc and `rd_ptr` += pop_acc, each 3-bit and wrapping 7→0.
  - Invariant checked by the bench: `wr_ptr − rd_ptr` (mod 8) equals `count` (mod 8).
- Strobe generation:
  - `wren`, `WrInc` and `push_ack` are the same combinational signal (push accepted).
  - `rden`, `RdInc` and `pop_ack` are the same combinational signal (pop accepted).
  - The accept logic depends only on the current registered state and `count` plus the current inputs. There is no combinational path from any output back to an input.
- `pop_valid` next value = pop_accepted. It is cleared by `rst`, but not by flush; a pop accepted in the flush-entry cycle cannot exist.

## Timing
- Accept decision: same cycle as the request (0-cycle handshake). The requester must hold `push`/`pop` until it sees its ack.
- Status after an accept: `count`, `full`, `empty` and `almost_full` reflect an accept in cycle N from cycle N+1.
- Read data: storage `DataOut` is valid in cycle N+1 after `pop_ack` in cycle N, qualified by `pop_valid`.
- Reset: the first accept is possible 2 cycles after the edge that sampled `rst`=1 with `rst` then low (1 cycle in `INIT`).
- Flush: `flush` sampled in cycle N puts the block in `FLUSH` in cycle N+1. Pointer clears are seen by storage at the edge ending N+1. Accepts resume in N+2.
- `rst` asserted mid-burst: the block is in `INIT` on the next cycle and stored data is discarded.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles, then low. Expect `INIT` for 1 cycle with both PtrClr=1, then `empty`=1, `count`=0, and no strobes.
- Fill: 8 consecutive pushes → `count` 1..8; `almost_full` rises when `count` reaches 6; `full`=1 after the 8th. A 9th push gives `push_ack`=0, `ovf_err`=1, `wr_ptr`=0.
- Drain: 8 pops from full → `pop_valid` pulses 1 cycle after each `pop_ack`, `count`→0, `empty`=1. A 9th pop sets `udf_err`=1 with `rden`=0.
- Simultaneous: at `count`=8, push+pop → both acked, `count` stays 8. At `count`=0, push+pop → push only, `count`=1, `udf_err`=1.
- Wrap: 5 pushes and 5 pops, repeated 3 times. Pointers wrap, `count` returns to 0, and the pointer/count invariant holds every cycle.
- Flush mid-operation: at `count`=5 with push and flush both high → no ack. Next cycle both PtrClr=1, and `count`=0 with errors cleared. Accepts resume 2 cycles after flush.
